ring_heater_tuner: RTL
======================

# ring_heater_tuner

Closed-loop thermal tuning controller for a ResonantRing. It reads drop-port photodetector samples and drives the ring's heater code. On enable it sweeps the full heater range to find the resonance peak, then hill-climbs to hold the ring on resonance as temperature drifts. It sits between the drop-port receiver ADC and the heater DAC of each ring instance.

## Interface
- CODE_W, 8, heater DAC code width
- PD_W, 12, photodetector sample width (unsigned)
- SETTLE_CYCLES, 16, cycles to wait after every heater_code change before a sample may be taken (1..255)
- STEP, 1, tracking dither step in codes (≥1)
- LOCK_THRESH, 12'd512, minimum drop power for a valid lock
- LOSS_COUNT, 4, consecutive below-threshold centre samples before re-sweep (1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run controller; low forces IDLE
- pd_valid  in  1  pd_data qualifier, may be high any cycle
- pd_data  in  PD_W  drop-port power sample
- heater_code  out  CODE_W  registered heater DAC code
- heater_update  out  1  one-cycle pulse on the cycle heater_code takes a new value
- locked  out  1  ring held on resonance
- sweep_fail  out  1  sweep found no peak ≥ LOCK_THRESH
- busy  out  1  high in SWEEP and TRACK

## Operation
- States: IDLE, SWEEP, CENTER, TRACK_P, TRACK_M, TRACK_0, FAIL.
- IDLE: heater_code=0, all flags 0. enable=1 → SWEEP, code=0, load settle counter.
- Settle/sample rule (all measuring states): each heater_code write loads the counter with SETTLE_CYCLES. The counter decrements to 0. The first pd_valid=1 cycle with counter==0 is the sample. pd_valid during settle is ignored.
- SWEEP: sample each code 0..2^CODE_W−1 in order. Record peak/argmax with strictly-greater compare, so ties keep the lowest code. After the max code is sampled: if peak < LOCK_THRESH → FAIL, else set code=argmax → CENTER.
- CENTER: settle and sample once (P0) → TRACK_P.
- TRACK_P: code=c+STEP (saturate at max), sample P+. Then TRACK_M: code=c−STEP (saturate at 0), sample P−. Then TRACK_0: code=c, sample P0.
- After TRACK_0, the new centre is chosen as follows:
  - If P+ > P0 and P+ ≥ P−, move to c+STEP.
  - Else if P− > P0, move to c−STEP.
  - Else stay at c.
  - If c is saturated, the probe is taken at c itself; it can never beat P0 under strict compare.
- Lock: locked=1 after any TRACK_0 or CENTER sample with P0 ≥ LOCK_THRESH. A below-threshold P0 increments the loss counter; an above-threshold P0 clears it. When the counter reaches LOSS_COUNT: locked=0, counter cleared, → SWEEP from code 0.
- FAIL: heater_code=0, sweep_fail=1, busy=0. Stays in FAIL until enable=0.
- enable=0 in any state: next edge → IDLE, heater_code=0, locked=sweep_fail=0, counters cleared. heater_update pulses only if the code was non-zero.
- Writing the same value to heater_code still reloads settle but does not pulse heater_update.

## Timing
- Reset: heater_code=0, heater_update=0, locked=0, sweep_fail=0, busy=0, state IDLE, peak/argmax/loss counters 0.
- enable rising at edge k: SWEEP entered at edge k+1, with heater_code=0 already.
- Code written at edge k: heater_update=1 during cycle k..k+1. The earliest sample capture is edge k+SETTLE_CYCLES+1, provided pd_valid=1 in the cycle before that edge. The next code is written on that same capture edge.
- Sweep duration with pd_valid held high: 2^CODE_W·(SETTLE_CYCLES+1) cycles.
- A tracking triplet takes 3·(SETTLE_CYCLES+1) cycles minimum. The centre decision and the next TRACK_P write happen on the TRACK_0 capture edge.
- Reset asserted mid-operation clears all state asynchronously. Deassertion resumes from IDLE.

## Test plan
- Sweep peak: CODE_W=4, SETTLE_CYCLES=2, LOCK_THRESH=100; model pd=1000−50·|code−9|, pd_valid always 1. Required: after 48 cycles heater_code=9, then locked=1 after CENTER, busy=1.
- Sweep fail: pd=50 constant. Required: sweep_fail=1, heater_code=0, busy=0; enable 0→1 restarts SWEEP at code 0.
- Drift tracking: lock at 9, then shift the model peak to 11. Required: heater_code moves 9→10→11 over two triplets and holds 11; locked stays 1.
- Loss/re-sweep: LOSS_COUNT=2; after lock force pd=0. Required: locked drops and SWEEP restarts at code 0 after the 2nd low P0.
- Settle gating: pd_valid pulses only during settle windows, then once at counter==0. Required: no sample is taken before the counter expires, and heater_code advances only after the valid pulse.
- Saturation/abort: peak at code 15; tracking probe at 15+STEP. Required: code saturates at 15 and stays there. Dropping enable mid-sweep gives heater_code=0 on the next edge. Reset mid-TRACK clears all outputs immediately.

Source files
------------

// File: rtl/ring_heater_tuner_if.sv
// Sample stream from the drop-port ADC and heater DAC control/status for one ring.
interface ring_heater_tuner_if #(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned PD_W   = 12
);
  logic              enable;
  logic              pd_valid;
  logic [PD_W-1:0]   pd_data;
  logic [CODE_W-1:0] heater_code;
  logic              heater_update;
  logic              locked;
  logic              sweep_fail;
  logic              busy;

  // Tuner side
  modport slave (
    input  enable,
    input  pd_valid,
    input  pd_data,
    output heater_code,
    output heater_update,
    output locked,
    output sweep_fail,
    output busy
  );

  // Host / ADC side
  modport master (
    output enable,
    output pd_valid,
    output pd_data,
    input  heater_code,
    input  heater_update,
    input  locked,
    input  sweep_fail,
    input  busy
  );
endinterface

// File: rtl/ring_heater_tuner.sv
// Thermal tuner for a resonant ring: full-range sweep to find the drop-port peak,
// then a three-point dither hill-climb to follow the resonance as it drifts.
module ring_heater_tuner #(
  parameter int unsigned CODE_W        = 8,
  parameter int unsigned PD_W          = 12,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STEP          = 1,
  parameter int unsigned LOCK_THRESH   = 512,
  parameter int unsigned LOSS_COUNT    = 4
) (
  input logic                clk,
  input logic                rst_n,
  ring_heater_tuner_if.slave bus
);

  localparam logic [CODE_W-1:0] MaxCode    = {CODE_W{1'b1}};
  localparam logic [CODE_W:0]   StepX      = (CODE_W + 1)'(STEP);
  localparam logic [7:0]        SettleInit = 8'(SETTLE_CYCLES);
  localparam logic [PD_W-1:0]   Thresh     = PD_W'(LOCK_THRESH);
  localparam logic [3:0]        LossMax    = 4'(LOSS_COUNT);

  typedef enum logic [2:0] {
    StIdle,
    StSweep,
    StCenter,
    StTrackP,
    StTrackM,
    StTrack0,
    StFail
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              upd_q, upd_d;
  logic [7:0]        settle_q, settle_d;
  logic [PD_W-1:0]   peak_q, peak_d;
  logic [CODE_W-1:0] argmax_q, argmax_d;
  logic [CODE_W-1:0] center_q, center_d;
  logic [PD_W-1:0]   pplus_q, pplus_d;
  logic [PD_W-1:0]   pminus_q, pminus_d;
  logic [3:0]        loss_q, loss_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;

  logic              measuring;
  logic              sample;
  logic              write;
  logic [CODE_W-1:0] new_code;
  logic [PD_W-1:0]   sw_peak;
  logic [CODE_W-1:0] sw_arg;
  logic              p0_ok;
  logic              loss_hit;
  logic [CODE_W-1:0] c_next;

  function automatic logic [CODE_W-1:0] sat_up(input logic [CODE_W-1:0] c);
    logic [CODE_W:0] sum;
    sum = {1'b0, c} + StepX;
    if (sum > {1'b0, MaxCode}) sat_up = MaxCode;
    else                       sat_up = sum[CODE_W-1:0];
  endfunction

  function automatic logic [CODE_W-1:0] sat_dn(input logic [CODE_W-1:0] c);
    if ({1'b0, c} < StepX) sat_dn = '0;
    else                   sat_dn = c - StepX[CODE_W-1:0];
  endfunction

  assign measuring = state_q inside {StSweep, StCenter, StTrackP, StTrackM, StTrack0};
  assign sample    = measuring && (settle_q == 8'd0) && bus.pd_valid;
  assign p0_ok     = bus.pd_data >= Thresh;
  assign loss_hit  = (loss_q + 4'd1) == LossMax;

  // Next-state: settle/sample sequencing, sweep peak search, dither decision, lock tracking
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    upd_d    = 1'b0;
    settle_d = settle_q;
    peak_d   = peak_q;
    argmax_d = argmax_q;
    center_d = center_q;
    pplus_d  = pplus_q;
    pminus_d = pminus_q;
    loss_d   = loss_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    write    = 1'b0;
    new_code = code_q;
    sw_peak  = peak_q;
    sw_arg   = argmax_q;
    c_next   = center_q;

    if (settle_q != 8'd0) settle_d = settle_q - 8'd1;

    if (!bus.enable) begin
      state_d  = StIdle;
      code_d   = '0;
      upd_d    = code_q != '0;
      settle_d = 8'd0;
      peak_d   = '0;
      argmax_d = '0;
      loss_d   = '0;
      locked_d = 1'b0;
      fail_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StSweep;
          new_code = '0;
          write    = 1'b1;
          peak_d   = '0;
          argmax_d = '0;
        end
        StSweep: begin
          if (sample) begin
            // Strict compare keeps the lowest code on ties
            if (bus.pd_data > peak_q) begin
              sw_peak = bus.pd_data;
              sw_arg  = code_q;
            end
            peak_d   = sw_peak;
            argmax_d = sw_arg;
            write    = 1'b1;
            if (code_q == MaxCode) begin
              if (sw_peak < Thresh) begin
                state_d  = StFail;
                fail_d   = 1'b1;
                new_code = '0;
              end else begin
                state_d  = StCenter;
                center_d = sw_arg;
                new_code = sw_arg;
              end
            end else begin
              new_code = code_q + 1'b1;
            end
          end
        end
        StCenter, StTrack0: begin
          if (sample) begin
            write = 1'b1;
            if (p0_ok) begin
              locked_d = 1'b1;
              loss_d   = '0;
            end else if (loss_hit) begin
              locked_d = 1'b0;
              loss_d   = '0;
            end else begin
              loss_d = loss_q + 4'd1;
            end

            if (!p0_ok && loss_hit) begin
              state_d  = StSweep;
              new_code = '0;
              peak_d   = '0;
              argmax_d = '0;
            end else begin
              if (state_q == StTrack0) begin
                if ((pplus_q > bus.pd_data) && (pplus_q >= pminus_q)) c_next = sat_up(center_q);
                else if (pminus_q > bus.pd_data)                      c_next = sat_dn(center_q);
                else                                                  c_next = center_q;
              end
              center_d = c_next;
              state_d  = StTrackP;
              new_code = sat_up(c_next);
            end
          end
        end
        StTrackP: begin
          if (sample) begin
            pplus_d  = bus.pd_data;
            state_d  = StTrackM;
            new_code = sat_dn(center_q);
            write    = 1'b1;
          end
        end
        StTrackM: begin
          if (sample) begin
            pminus_d = bus.pd_data;
            state_d  = StTrack0;
            new_code = center_q;
            write    = 1'b1;
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      // Every write restarts settling; only a real change pulses the DAC strobe
      if (write) begin
        code_d   = new_code;
        upd_d    = new_code != code_q;
        settle_d = SettleInit;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      code_q   <= '0;
      upd_q    <= 1'b0;
      settle_q <= 8'd0;
      peak_q   <= '0;
      argmax_q <= '0;
      center_q <= '0;
      pplus_q  <= '0;
      pminus_q <= '0;
      loss_q   <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      upd_q    <= upd_d;
      settle_q <= settle_d;
      peak_q   <= peak_d;
      argmax_q <= argmax_d;
      center_q <= center_d;
      pplus_q  <= pplus_d;
      pminus_q <= pminus_d;
      loss_q   <= loss_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.heater_code   = code_q;
  assign bus.heater_update = upd_q;
  assign bus.locked        = locked_q;
  assign bus.sweep_fail    = fail_q;
  assign bus.busy          = measuring;

endmodule
